// File: rtl/spi_flash_pkg.sv
// Shared command codes, FSM state encoding and status-register layout for spi_flash_responder.
package spi_flash_pkg;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_PROG = 8'h02;
  localparam logic [7:0] CMD_WREN = 8'h06;
  localparam logic [7:0] CMD_RDSR = 8'h05;

  localparam int STS_WIP = 0;
  localparam int STS_WEL = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_READ,
    S_PROG,
    S_STATUS,
    S_IGNORE
  } state_t;

  function automatic logic [7:0] status_byte(input logic wel, input logic wip);
    logic [7:0] sts;
    sts          = '0;
    sts[STS_WEL] = wel;
    sts[STS_WIP] = wip;
    return sts;
  endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Brings the asynchronous SPI pins into the clk domain and produces one-cycle SCK/CS edge events.
module spi_slave_sync (
  input  logic clk,
  input  logic reset,
  input  logic sck,
  input  logic mosi,
  input  logic cs,
  output logic sck_rise,
  output logic sck_fall,
  output logic cs_fall,
  output logic cs_rise,
  output logic mosi_s
);

  // [0] metastability flop, [1] synchronized level, [2] previous synchronized level
  logic [2:0] sck_sh;
  logic [2:0] cs_sh;
  logic [1:0] mosi_sh;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sh   <= 3'b000;
      cs_sh    <= 3'b111;
      mosi_sh  <= 2'b00;
      sck_rise <= 1'b0;
      sck_fall <= 1'b0;
      cs_fall  <= 1'b0;
      cs_rise  <= 1'b0;
    end else begin
      sck_sh   <= {sck_sh[1:0], sck};
      cs_sh    <= {cs_sh[1:0], cs};
      mosi_sh  <= {mosi_sh[0], mosi};
      sck_rise <= sck_sh[1] & ~sck_sh[2];
      sck_fall <= ~sck_sh[1] & sck_sh[2];
      cs_fall  <= ~cs_sh[1] & cs_sh[2];
      cs_rise  <= cs_sh[1] & ~cs_sh[2];
    end
  end

  assign mosi_s = mosi_sh[1];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial-flash stand-in (READ/WREN/PAGE PROGRAM) backed by block RAM.
// Define SPI_FLASH_RESP_RDSR_EN to add the RDSR (0x05) status-read command.
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int ADDR_W       = 12,
  parameter int PAGE_W       = 8,
  parameter int WRITE_CYCLES = 48000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_SPI_CLK,
  input  logic              i_SPI_MOSI,
  input  logic              i_SPI_CS,
  output logic              o_SPI_MISO,
  output logic              o_MISO_OE,
  output logic              o_busy,
  output logic              o_wr_strobe,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [7:0]        o_wr_data
);

  localparam int CNT_W = $clog2(WRITE_CYCLES + 1);

  logic sck_rise, sck_fall, cs_fall, cs_rise, mosi_s;

  spi_slave_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .sck      (i_SPI_CLK),
    .mosi     (i_SPI_MOSI),
    .cs       (i_SPI_CS),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .cs_fall  (cs_fall),
    .cs_rise  (cs_rise),
    .mosi_s   (mosi_s)
  );

  state_t              state;
  logic [4:0]          bit_cnt;
  logic [7:0]          rx_sr;
  logic [7:0]          tx_sr;
  logic [ADDR_W-1:0]   addr;
  logic                is_prog;
  logic                wren_pend;
  logic                byte_done;
  logic                wel;
  logic                wip;
  logic [CNT_W-1:0]    wip_cnt;

  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [7:0]          ram_wdata;
  logic [7:0]          ram_rdata;
  logic [7:0]          mem [2**ADDR_W];

  logic [7:0]          rx_byte;
  logic [ADDR_W-1:0]   addr_next;
  logic [ADDR_W-1:0]   addr_inc;
  logic [PAGE_W-1:0]   page_lo_inc;
  logic [ADDR_W-1:0]   addr_page_inc;
  logic [7:0]          tx_src;

  assign rx_byte       = {rx_sr[6:0], mosi_s};
  assign addr_next     = {addr[ADDR_W-2:0], mosi_s};
  assign addr_inc      = addr + ADDR_W'(1);
  assign page_lo_inc   = addr[PAGE_W-1:0] + PAGE_W'(1);
  assign addr_page_inc = {addr[ADDR_W-1:PAGE_W], page_lo_inc};
  // Status is sampled live at each byte start, so a poll loop sees WIP drop mid-transaction.
  assign tx_src        = (state == S_STATUS) ? status_byte(wel, wip) : ram_rdata;
  assign o_busy        = wip;

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      bit_cnt     <= '0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      addr        <= '0;
      is_prog     <= 1'b0;
      wren_pend   <= 1'b0;
      byte_done   <= 1'b0;
      wel         <= 1'b0;
      wip         <= 1'b0;
      wip_cnt     <= '0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      o_SPI_MISO  <= 1'b0;
      o_MISO_OE   <= 1'b0;
      o_wr_strobe <= 1'b0;
      o_wr_addr   <= '0;
      o_wr_data   <= '0;
    end else begin
      ram_we      <= 1'b0;
      o_wr_strobe <= 1'b0;

      if (wip) begin
        if (wip_cnt == '0) wip <= 1'b0;
        else               wip_cnt <= wip_cnt - CNT_W'(1);
      end

      // CS rise takes priority over any SCK edge seen in the same cycle.
      if (cs_rise) begin
        state      <= S_IDLE;
        o_MISO_OE  <= 1'b0;
        o_SPI_MISO <= 1'b0;
        if (state == S_PROG && byte_done && bit_cnt == 5'd0) begin
          wel     <= 1'b0;
          wip     <= 1'b1;
          wip_cnt <= CNT_W'(WRITE_CYCLES - 1);
        end
        if (wren_pend && !wip) wel <= 1'b1;
      end else if (cs_fall) begin
        state      <= S_CMD;
        bit_cnt    <= '0;
        rx_sr      <= '0;
        is_prog    <= 1'b0;
        wren_pend  <= 1'b0;
        byte_done  <= 1'b0;
        o_MISO_OE  <= 1'b0;
        o_SPI_MISO <= 1'b0;
      end else begin
        case (state)
          S_CMD: begin
            if (sck_rise) begin
              rx_sr <= rx_byte;
              if (bit_cnt == 5'd7) begin
                bit_cnt <= '0;
                case (rx_byte)
                  CMD_READ: state <= wip ? S_IGNORE : S_ADDR;
                  CMD_PROG: begin
                    if (wel && !wip) begin
                      state   <= S_ADDR;
                      is_prog <= 1'b1;
                    end else begin
                      state <= S_IGNORE;
                    end
                  end
                  CMD_WREN: begin
                    state     <= S_IGNORE;
                    wren_pend <= 1'b1;
                  end
`ifdef SPI_FLASH_RESP_RDSR_EN
                  CMD_RDSR: state <= S_STATUS;
`else
                  CMD_RDSR: state <= S_IGNORE;
`endif
                  default:  state <= S_IGNORE;
                endcase
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end

          S_ADDR: begin
            if (sck_rise) begin
              addr <= addr_next;
              if (bit_cnt == 5'd23) begin
                bit_cnt <= '0;
                if (is_prog) begin
                  state <= S_PROG;
                end else begin
                  state    <= S_READ;
                  ram_addr <= addr_next;
                end
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end

          S_READ, S_STATUS: begin
            if (sck_rise) begin
              if (bit_cnt == 5'd7) begin
                bit_cnt <= '0;
                if (state == S_READ) begin
                  addr     <= addr_inc;
                  ram_addr <= addr_inc;
                end
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end else if (sck_fall) begin
              o_MISO_OE <= 1'b1;
              if (bit_cnt == 5'd0) begin
                o_SPI_MISO <= tx_src[7];
                tx_sr      <= {tx_src[6:0], 1'b0};
              end else begin
                o_SPI_MISO <= tx_sr[7];
                tx_sr      <= {tx_sr[6:0], 1'b0};
              end
            end
          end

          S_PROG: begin
            if (sck_rise) begin
              rx_sr <= rx_byte;
              if (bit_cnt == 5'd7) begin
                bit_cnt     <= '0;
                ram_we      <= 1'b1;
                ram_addr    <= addr;
                ram_wdata   <= rx_byte;
                o_wr_strobe <= 1'b1;
                o_wr_addr   <= addr;
                o_wr_data   <= rx_byte;
                addr        <= addr_page_inc;
                byte_done   <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end

          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/spi_flash_responder.md
# spi_flash_responder

SPI Mode 0 slave that answers the 6809-side flash controller with a byte-addressed serial-flash command set (READ 0x03, WREN 0x06, PAGE PROGRAM 0x02, optional RDSR 0x05) backed by on-chip block RAM. It is the far end of the existing flash SPI bus. It serves as a flash stand-in on boards without a populated part, and as a synthesizable bus-functional model in system simulation. All SPI pins are oversampled in the `clk` domain.

## Interface
- `ADDR_W`, 12 — memory address width; depth 2**ADDR_W bytes; upper bits of the 24-bit SPI address ignored
- `PAGE_W`, 8 — page size 2**PAGE_W bytes for program wrap
- `WRITE_CYCLES`, 48000 — `clk` cycles WIP stays set after a program
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `i_SPI_CLK`  in  1  SPI clock from master, idle low
- `i_SPI_MOSI`  in  1  master-out data
- `i_SPI_CS`  in  1  chip select, active low
- `o_SPI_MISO`  out  1  slave-out data
- `o_MISO_OE`  out  1  MISO output enable; top level tristates when 0
- `o_busy`  out  1  WIP flag mirror
- `o_wr_strobe`  out  1  one-cycle pulse per programmed byte
- `o_wr_addr`  out  ADDR_W  address of programmed byte
- `o_wr_data`  out  8  data of programmed byte

## Operation
- Input sync: 2-flop synchronizers on SCK, MOSI and CS, plus one delayed SCK copy for edge detect. MOSI is sampled on the SCK rise event. MISO is updated on the SCK fall event.
- CS fall event: clear bit counter and shift register, enter CMD.
- CS rise event from any state: return to IDLE, discard partial byte, set `o_MISO_OE`=0.
- FSM states: IDLE, CMD, ADDR, READ, PROG, STATUS, IGNORE.
- CMD, after 8 rises:
  - 0x03 → ADDR (read); ignored while WIP
  - 0x02 → ADDR (program); requires WEL=1 and WIP=0
  - 0x06 → IGNORE; sets WEL at CS rise if WIP=0
  - 0x05 → STATUS (RDSR build only); allowed while WIP
  - anything else → IGNORE
- ADDR: shift 24 bits MSB first, then go to READ or PROG.
- READ:
  - Issue a RAM read on the 32nd rise.
  - Drive bit7 on the following fall, with `o_MISO_OE`=1.
  - Continue MSB first; after each 8 bits, address+1 wrapping mod 2**ADDR_W; stream continues until CS rise.
- PROG:
  - Each complete byte is written to RAM at current address and `o_wr_strobe` pulses.
  - Address low PAGE_W bits increment with wrap inside the page; upper bits are held.
  - At CS rise with ≥1 byte written: WEL←0, WIP←1, load counter with WRITE_CYCLES.
  - PROG with zero bytes, or CS rise mid-byte: WEL unchanged, no WIP.
- WIP: counter decrements each `clk`; at 0, WIP←0.
- MISO drive: MISO is driven only in READ and STATUS; otherwise `o_MISO_OE`=0 and `o_SPI_MISO`=0.
- Reset mid-transaction: immediate IDLE, WIP=0, WEL=0. RAM contents are preserved.

## Timing
- Reset values: `o_SPI_MISO`=0, `o_MISO_OE`=0, `o_busy`=0, `o_wr_strobe`=0, `o_wr_addr`=0, `o_wr_data`=0, WEL=0, FSM=IDLE.
- Pin edge to internal event: 3 `clk` cycles. Fall pin edge to `o_SPI_MISO` valid: 4 `clk` cycles.
- SCK high and low phases must each be ≥6 `clk` cycles (SCK ≤ clk/12). Faster SCK is unsupported; behaviour is undefined.
- RAM: single-port synchronous, 1-cycle read. Read data is ready ≥2 cycles before the next fall event.
- `o_wr_strobe` asserts 1 cycle after the 8th rise event of a data byte. `o_wr_addr` and `o_wr_data` are valid in the same cycle.
- WIP asserts 1 cycle after the CS rise event and is held for exactly WRITE_CYCLES cycles.
- Simultaneous CS rise and SCK edge: CS wins; the edge is ignored.

## Configuration
- `SPI_FLASH_RESP_RDSR_EN`:
  - Defined: 0x05 returns status {6'b0, WEL, WIP}, repeated every 8 clocks until CS rise, sampled live at each byte start.
  - Undefined: 0x05 → IGNORE, MISO stays disabled; the master must poll by timing only.

## Structure
- Package `spi_flash_pkg` holds:
  - command constants CMD_READ=8'h03, CMD_PROG=8'h02, CMD_WREN=8'h06, CMD_RDSR=8'h05
  - FSM state enum
  - status bit indices
- Sub-module `spi_slave_sync`: synchronizers and edge detect for SCK/CS, plus synchronized MOSI. It outputs `sck_rise`, `sck_fall`, `cs_fall`, `cs_rise`, `mosi_s`.

## Test plan
- Preload RAM[0x123]=0xA5. Master sends 03 00 01 23 then 8 clocks → MISO returns 0xA5. A further 8 clocks → RAM[0x124].
- Sequence 06 with CS pulse, then 02 00 00 FF 11 22, CS high → RAM[0x0FF]=0x11, RAM[0x000]=0x22 (page wrap); two `o_wr_strobe` pulses; `o_busy` high for WRITE_CYCLES cycles; WEL=0.
- 02 00 00 10 55 without prior WREN → no strobe, RAM[0x010] unchanged, `o_busy` stays 0.
- During WIP: 03 00 00 10 → `o_MISO_OE` stays 0. With RDSR: 05 → 0x01 while busy, then 0x00 after expiry.
- CS raised after 13 bits of an address phase, then a fresh READ of 0x000 → correct data; no residual state.
- `reset` asserted mid-PROG data byte → all outputs return to reset values within the same cycle; earlier completed bytes remain in RAM.
